// File: rtl/iso_pkg.sv
// Shared FSM encoding and default sizing for the isolated adder controller.
package iso_pkg;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_IDLE_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SLEEP   = 3'd1,
        WAKE    = 3'd2,
        COMPUTE = 3'd3,
        HOLD    = 3'd4
    } state_t;

endpackage

// File: rtl/operand_isolation_adder.sv
// Adder whose operands are forced to zero while disabled, so the carry chain
// stays quiet between transfers.
module operand_isolation_adder #(
    parameter int WIDTH = 8
) (
    input  logic             enable,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] gated_a;
    logic [WIDTH-1:0] gated_b;

    assign gated_a = a & {WIDTH{enable}};
    assign gated_b = b & {WIDTH{enable}};
    // Carry out is dropped: the result wraps modulo 2^WIDTH.
    assign sum     = gated_a + gated_b;

endmodule

// File: rtl/isolated_add_ctrl.sv
// Handshaked single-operation adder controller with operand isolation and an
// idle-driven SLEEP state that costs one extra wake cycle on the next transfer.
module isolated_add_ctrl
    import iso_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             iso_enable,
    output logic             sleep
);

    localparam int              CNT_W    = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SLEEP_AT = CNT_W'(IDLE_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] idle_cnt_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] adder_sum;
    logic             accept;

    assign accept = in_valid & in_ready;

    // In IDLE in_ready is always high, so in_valid implies accept; that is
    // what gives accept priority over falling asleep on the same edge.
    always_comb begin
        state_next    = state;
        idle_cnt_next = idle_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next    = COMPUTE;
                    idle_cnt_next = '0;
                end else if (!in_valid) begin
                    if (idle_cnt == SLEEP_AT) begin
                        state_next    = SLEEP;
                        idle_cnt_next = '0;
                    end else begin
                        idle_cnt_next = idle_cnt + 1'b1;
                    end
                end
            end
            SLEEP: begin
                if (accept) begin
                    state_next = WAKE;
                end
            end
            WAKE:    state_next = COMPUTE;
            COMPUTE: state_next = HOLD;
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next    = IDLE;
                idle_cnt_next = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state
    // register and never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idle_cnt   <= '0;
            op_a       <= '0;
            op_b       <= '0;
            out_sum    <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            iso_enable <= 1'b0;
            sleep      <= 1'b0;
        end else begin
            state    <= state_next;
            idle_cnt <= idle_cnt_next;
            if (accept) begin
                op_a <= in_a;
                op_b <= in_b;
            end
            if (state == COMPUTE) begin
                out_sum <= adder_sum;
            end
            in_ready   <= (state_next == IDLE) || (state_next == SLEEP);
            out_valid  <= (state_next == HOLD);
            iso_enable <= (state_next == COMPUTE);
            sleep      <= (state_next == SLEEP);
        end
    end

    operand_isolation_adder #(
        .WIDTH(WIDTH)
    ) u_adder (
        .enable(iso_enable),
        .a     (op_a),
        .b     (op_b),
        .sum   (adder_sum)
    );

endmodule

// File: doc/isolated_add_ctrl.md
ISOLATED_ADD_CTRL -- requirements
Module: isolated_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and sum width.
REQ-002 SHALL have parameter IDLE_CYCLES, default 4, idle cycles before sleep (at least 1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream operand pair valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-007 SHALL have port in_a  input  WIDTH  operand A.
REQ-008 SHALL have port in_b  input  WIDTH  operand B.
REQ-009 SHALL have port out_valid  output  1  out_sum valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_sum.
REQ-011 SHALL have port out_sum  output  WIDTH  registered result, (A+B) mod 2^WIDTH.
REQ-012 SHALL have port iso_enable  output  1  isolation enable driven to the adder datapath.
REQ-013 SHALL have port sleep  output  1  block is in the low-activity SLEEP state.

Function
REQ-014 SHALL implement an FSM with states IDLE, SLEEP, WAKE, COMPUTE and HOLD.
REQ-015 SHALL drive in_ready=1 only in IDLE and SLEEP.
REQ-016 SHALL accept a transfer on a rising edge where in_valid and in_ready are both 1.
REQ-017 SHALL load the operand registers only on accept, so adder inputs never toggle otherwise.
REQ-018 SHALL transition IDLE to COMPUTE on accept.
REQ-019 SHALL transition SLEEP to WAKE on accept, then WAKE to COMPUTE unconditionally (one-cycle wake penalty).
REQ-020 SHALL drive iso_enable=1 only in COMPUTE, for exactly one cycle per transfer.
REQ-021 SHALL transition COMPUTE to HOLD, capturing the adder sum into out_sum on that edge.
REQ-022 SHALL give latency from an accepting edge in IDLE to out_valid=1 of 1 edge; from SLEEP, 2 edges.
REQ-023 SHALL drive out_valid=1 only in HOLD.
REQ-024 SHALL hold out_sum stable while out_valid=1 and out_ready=0.
REQ-025 SHALL transition HOLD to IDLE on an edge with out_ready=1.
REQ-026 SHALL not accept input in HOLD, even when out_ready and in_valid are both 1 (no overlap).
REQ-027 SHALL retain out_sum after HOLD, changing it only at the next COMPUTE capture.
REQ-028 SHALL use an idle counter of width clog2(IDLE_CYCLES+1), incremented each IDLE cycle with in_valid=0.
REQ-029 SHALL clear the idle counter on accept and on any exit from IDLE.
REQ-030 SHALL enter SLEEP on the edge where the idle counter equals IDLE_CYCLES-1 and in_valid=0.
REQ-031 SHALL give accept priority over the SLEEP transition when both occur on the same edge.
REQ-032 SHALL drive sleep=1 only in SLEEP, as a registered state decode.
REQ-033 SHALL produce out_sum modulo 2^WIDTH, discarding the carry out.

Reset
REQ-034 SHALL, on rst=1 asynchronously, set state=IDLE and clear the idle counter.
REQ-035 SHALL, on rst=1 asynchronously, set the operand registers and out_sum to 0.
REQ-036 SHALL, on rst=1 asynchronously, drive in_valid-independent outputs to: in_ready=1, out_valid=0, iso_enable=0, sleep=0.
REQ-037 SHALL abort any in-flight transfer on reset mid-operation (WAKE, COMPUTE or HOLD), with no result produced.

Structure
REQ-038 SHALL place FSM state encodings and default WIDTH/IDLE_CYCLES constants in shared package iso_pkg.
REQ-039 SHALL instantiate one sub-module, operand_isolation_adder (ports enable, a, b, sum), fed by the operand registers and iso_enable.
REQ-040 SHALL sample the sub-module sum only in COMPUTE, so its value while disabled is irrelevant.

Verification
REQ-041 SHALL verify: accept 0x0F+0xF0 from IDLE, out_ready=1 -> iso_enable one cycle, out_valid next edge, out_sum=0xFF.
REQ-042 SHALL verify: 0xFF+0x01 -> out_sum=0x00 (wrap-around).
REQ-043 SHALL verify: 0xAA+0x55 with out_ready=0 for 5 cycles -> out_valid held, out_sum=0xFF stable, in_ready=0, new in_valid ignored.
REQ-044 SHALL verify: 4 idle cycles -> sleep=1; then accept 0x01+0x02 -> WAKE, COMPUTE, out_sum=0x03 at edge 2.
REQ-045 SHALL verify: in_valid on the edge the counter reaches 3 -> accept wins, sleep stays 0.
REQ-046 SHALL verify: rst asserted in COMPUTE -> immediate IDLE, out_valid=0, out_sum=0x00, iso_enable=0.
